fetch_decode_queue: RTL and testbench

- Parametrised successor to the fetch/decode pipeline register.
- Replaces the single F->D flop stage with a DEPTH-entry instruction queue.
- Lets fetch keep running while decode is stalled; adds valid/ready handshaking and queue-wide flush.
- Sits between instruction memory / PC+4 logic (F side) and the decoder plus hazard unit (D side).

---
 rtl/fetch_decode_queue.sv | 77 +++++++
 tb/tb_fetch_decode_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry F->D instruction queue; a push into an empty queue reaches the D outputs one cycle later.
// Fetch sees readyF=0 only when the queue is full, and readyF comes from the registered count alone.
module fetch_decode_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flushD,
  input  logic                       stallD,
  input  logic                       validF,
  input  logic [DATA_WIDTH-1:0]      instrF,
  input  logic [DATA_WIDTH-1:0]      PCounterF,
  input  logic [DATA_WIDTH-1:0]      PCPlus4F,
  output logic                       readyF,
  output logic                       validD,
  output logic [DATA_WIDTH-1:0]      InstrD,
  output logic [DATA_WIDTH-1:0]      PCounterD,
  output logic [DATA_WIDTH-1:0]      PCPlus4D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pcplus4;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign readyF = (count != CW'(DEPTH));
  assign validD = (count != '0);
  assign push   = validF && readyF;
  assign pop    = validD && !stallD;

  // Pointers wrap naturally; full and empty are told apart by count only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flushD) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible unless count says it is valid.
  always_ff @(posedge clk) begin
    if (push && !flushD) begin
      mem[wr_ptr] <= '{instr: instrF, pc: PCounterF, pcplus4: PCPlus4F};
    end
  end

  assign head      = mem[rd_ptr];
  assign InstrD    = validD ? head.instr   : '0;
  assign PCounterD = validD ? head.pc      : '0;
  assign PCPlus4D  = validD ? head.pcplus4 : '0;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: stream, stall fill/drain, wrap, flush, async reset.
module tb_fetch_decode_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flushD, stallD, validF;
  logic [DW-1:0] instrF, PCounterF, PCPlus4F;
  logic          readyF, validD;
  logic [DW-1:0] InstrD, PCounterD, PCPlus4D;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_decode_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flushD(flushD), .stallD(stallD), .validF(validF),
    .instrF(instrF), .PCounterF(PCounterF), .PCPlus4F(PCPlus4F),
    .readyF(readyF), .validD(validD), .InstrD(InstrD), .PCounterD(PCounterD),
    .PCPlus4D(PCPlus4D), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      assert (count <= CW'(DEPTH)) else $error("FAIL count_bound: count=%0d", count);
      assert (!(validD && !stallD && count == 0)) else $error("FAIL pop_empty");
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    validF    = v;
    instrF    = ins;
    PCounterF = pc;
    PCPlus4F  = pc + 32'd4;
  endtask

  initial begin
    rst = 1'b1; flushD = 1'b0; stallD = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk("rst_count",  32'(count), 32'd0);
    chk("rst_readyF", 32'(readyF), 32'd1);
    chk("rst_validD", 32'(validD), 32'd0);
    chk("rst_instrD", InstrD, 32'h0);
    step; step;
    rst = 1'b0;

    // Stream: one push per cycle with decode consuming every cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h13 + i, 32'(4 * i));
      step;
      chk("strm_validD", 32'(validD), 32'd1);
      chk("strm_instr",  InstrD,    32'h13 + i);
      chk("strm_pc",     PCounterD, 32'(4 * i));
      chk("strm_pc4",    PCPlus4D,  32'(4 * i + 4));
      chk("strm_count",  32'(count), 32'd1);
      chk("strm_readyF", 32'(readyF), 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0);
    step;
    chk("strm_empty", 32'(count), 32'd0);

    // Fill while decode is stalled; the 5th push must be refused
    stallD = 1'b1;
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 32'h100 + j, 32'h1000 + 32'(4 * j));
      step;
      chk("fill_count",  32'(count), (j < 4) ? 32'(j + 1) : 32'd4);
      chk("fill_readyF", 32'(readyF), (j < 3) ? 32'd1 : 32'd0);
      chk("fill_head",   InstrD, 32'h100);
    end

    // Drain in order
    drive(1'b0, 32'h0, 32'h0);
    stallD = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("drain_instr", InstrD, 32'h100 + k);
      chk("drain_pc",    PCounterD, 32'h1000 + 32'(4 * k));
      chk("drain_count", 32'(count), 32'(4 - k));
      step;
    end
    chk("drain_validD", 32'(validD), 32'd0);
    chk("drain_instr0", InstrD, 32'h0);
    chk("drain_count0", 32'(count), 32'd0);

    // Hold count=2 with simultaneous push/pop across pointer wrap
    stallD = 1'b1;
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 32'h200 + n, 32'h2000 + 32'(4 * n));
      step;
    end
    chk("wrap_pre_count", 32'(count), 32'd2);
    stallD = 1'b0;
    for (int n = 0; n < 10; n++) begin
      drive(1'b1, 32'h202 + n, 32'h2008 + 32'(4 * n));
      step;
      chk("wrap_count", 32'(count), 32'd2);
      chk("wrap_head",  InstrD, 32'h201 + n);
      chk("wrap_pc4",   PCPlus4D, 32'h2008 + 32'(4 * n));
    end

    // Flush from count=3 with a push in the flush cycle
    stallD = 1'b1;
    drive(1'b1, 32'h20C, 32'h2030);
    step;
    chk("fl_pre_count", 32'(count), 32'd3);
    flushD = 1'b1; stallD = 1'b0;
    drive(1'b1, 32'hDEAD, 32'hBEE0);
    step;
    flushD = 1'b0;
    chk("fl_count",  32'(count), 32'd0);
    chk("fl_validD", 32'(validD), 32'd0);
    chk("fl_instr",  InstrD, 32'h0);
    chk("fl_pc",     PCounterD, 32'h0);
    chk("fl_pc4",    PCPlus4D, 32'h0);
    chk("fl_readyF", 32'(readyF), 32'd1);
    drive(1'b1, 32'h300, 32'h3000);
    step;
    chk("fl_next_validD", 32'(validD), 32'd1);
    chk("fl_next_instr",  InstrD, 32'h300);
    chk("fl_next_count",  32'(count), 32'd1);

    // Flush with stall also high: flush wins
    stallD = 1'b1; flushD = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step;
    flushD = 1'b0;
    chk("flst_count", 32'(count), 32'd0);

    // Async reset between edges with count=3
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h400 + k, 32'h4000 + 32'(4 * k));
      step;
    end
    chk("ar_pre_count", 32'(count), 32'd3);
    drive(1'b0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("ar_count",  32'(count), 32'd0);
    chk("ar_validD", 32'(validD), 32'd0);
    chk("ar_readyF", 32'(readyF), 32'd1);
    chk("ar_instr",  InstrD, 32'h0);
    chk("ar_pc",     PCounterD, 32'h0);
    step;
    rst = 1'b0; stallD = 1'b0;
    drive(1'b1, 32'h500, 32'h5000);
    step;
    chk("ar_post_validD", 32'(validD), 32'd1);
    chk("ar_post_instr",  InstrD, 32'h500);
    chk("ar_post_pc4",    PCPlus4D, 32'h5004);
    chk("ar_post_count",  32'(count), 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    step;
    chk("ar_end_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
